lcd_refresh_spi: RTL and testbench

LCD_REFRESH_SPI -- requirements
Module: lcd_refresh_spi

---
 rtl/lcd_refresh_spi.sv | 169 ++++++++++++++++
 tb/tb_lcd_refresh_spi.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_spi.sv
// rtl/lcd_refresh_spi.sv - full-frame LCD refresh over SPI mode 0
// Streams 8 pages of {3 command bytes, 128 screen-RAM bytes} per start request.
module lcd_refresh_spi #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [9:0] addr_rd,
    output logic       rd,
    input  logic [7:0] d_in,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     r_state;
    logic [2:0] r_page;
    logic [6:0] r_col;
    logic [1:0] r_cmd_idx;
    logic [7:0] r_sr;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic       r_busy;
    logic       r_done;
    logic       r_rd;
    logic [9:0] r_addr;
    logic       r_cs_n;
    logic       r_dc;
    logic       r_sclk;
    logic       r_mosi;
    logic [7:0] w_cmd_byte;

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd       = r_rd;
    assign addr_rd  = r_addr;
    assign lcd_cs_n = r_cs_n;
    assign lcd_dc   = r_dc;
    assign lcd_sclk = r_sclk;
    assign lcd_mosi = r_mosi;

    // Page preamble: set page address, then column high/low nibbles to zero.
    always_comb begin
        w_cmd_byte = 8'h00;
        case (r_cmd_idx)
            2'd0:    w_cmd_byte = {5'b10110, r_page};
            2'd1:    w_cmd_byte = 8'h10;
            default: w_cmd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_page    <= 3'd0;
            r_col     <= 7'd0;
            r_cmd_idx <= 2'd0;
            r_sr      <= 8'h00;
            r_div     <= 8'd0;
            r_bit     <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= 10'd0;
            r_cs_n    <= 1'b1;
            r_dc      <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_page    <= 3'd0;
                        r_col     <= 7'd0;
                        r_cmd_idx <= 2'd0;
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CMD;
                    end
                end
                S_CMD: begin
                    r_sr    <= w_cmd_byte;
                    r_mosi  <= w_cmd_byte[7];
                    r_dc    <= 1'b0;
                    r_div   <= 8'd0;
                    r_bit   <= 3'd0;
                    r_state <= S_SHIFT;
                end
                S_FETCH: begin
                    r_rd    <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_sr    <= d_in;
                    r_mosi  <= d_in[7];
                    r_dc    <= 1'b1;
                    r_div   <= 8'd0;
                    r_bit   <= 3'd0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div <= 8'd0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling edge: mosi and the next-byte decision move only here.
                            r_sclk <= 1'b0;
                            if (r_bit != 3'd7) begin
                                r_bit  <= r_bit + 3'd1;
                                r_sr   <= {r_sr[6:0], 1'b0};
                                r_mosi <= r_sr[6];
                            end else if (!r_dc) begin
                                if (r_cmd_idx == 2'd2) begin
                                    r_cmd_idx <= 2'd0;
                                    r_rd      <= 1'b1;
                                    r_addr    <= {r_page, r_col};
                                    r_state   <= S_FETCH;
                                end else begin
                                    r_cmd_idx <= r_cmd_idx + 2'd1;
                                    r_state   <= S_CMD;
                                end
                            end else if (r_col != 7'd127) begin
                                r_col   <= r_col + 7'd1;
                                r_rd    <= 1'b1;
                                r_addr  <= {r_page, r_col + 7'd1};
                                r_state <= S_FETCH;
                            end else begin
                                r_col <= 7'd0;
                                if (r_page == 3'd7) begin
                                    r_done  <= 1'b1;
                                    r_cs_n  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_page  <= r_page + 3'd1;
                                    r_state <= S_CMD;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_refresh_spi.sv
// tb/tb_lcd_refresh_spi.sv - directed bench for lcd_refresh_spi (CLK_DIV=1 and CLK_DIV=3)
module tb_lcd_refresh_spi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic       busy, done, rd, cs_n, dc, sclk, mosi;
    logic [9:0] addr;
    logic [7:0] ram_q = 8'h00;
    logic       busy3, done3, rd3, cs_n3, dc3, sclk3, mosi3;
    logic [9:0] addr3;
    logic [7:0] ram3_q = 8'h00;

    lcd_refresh_spi #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .addr_rd(addr), .rd(rd), .d_in(ram_q), .lcd_cs_n(cs_n),
        .lcd_dc(dc), .lcd_sclk(sclk), .lcd_mosi(mosi)
    );

    lcd_refresh_spi #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .addr_rd(addr3), .rd(rd3), .d_in(ram3_q), .lcd_cs_n(cs_n3),
        .lcd_dc(dc3), .lcd_sclk(sclk3), .lcd_mosi(mosi3)
    );

    // Screen RAMs: synchronous read, data valid the cycle after rd.
    always @(posedge clk) if (rd) ram_q <= (addr == 10'h185) ? 8'hA5 : 8'h00;
    always @(posedge clk) if (rd3) ram3_q <= addr3[7:0] ^ 8'h5A;

    int n_checks = 0;
    int n_err = 0;

    int nb, rises, bitc, rd_cnt, rd_err, done_cnt, stab_err, cs_err, hi_err, lo_err, hi_len, lo_len;
    logic [7:0] sh;
    logic [7:0] bytes [0:1099];
    logic       bdc [0:1099];
    logic       p_sclk = 1'b0, p_mosi = 1'b0, p_dc = 1'b0, p_rd = 1'b0;

    int nb3, rises3, bitc3, stab_err3, hi_err3, lo_err3, hi_len3, lo_len3, hi_n3;
    logic [7:0] sh3;
    logic [7:0] bytes3 [0:15];
    logic       bdc3 [0:15];
    logic       p_sclk3 = 1'b0, p_mosi3 = 1'b0, p_dc3 = 1'b0;

    always @(negedge clk) begin
        if (sclk && p_sclk && (mosi !== p_mosi || dc !== p_dc)) stab_err++;
        if (sclk && !p_sclk) begin
            if (rises % 8 != 0 && lo_len != 1) lo_err++;
            rises++;
            hi_len = 1;
            sh = {sh[6:0], mosi};
            bitc++;
            if (bitc == 8) begin
                bitc = 0;
                if (nb < 1100) begin
                    bytes[nb] = sh;
                    bdc[nb] = dc;
                end
                nb++;
            end
        end else if (sclk) begin
            hi_len++;
        end else if (p_sclk) begin
            if (hi_len != 1) hi_err++;
            lo_len = 1;
        end else begin
            lo_len++;
        end
        if (rd) begin
            if (p_rd || !busy || addr !== rd_cnt[9:0]) rd_err++;
            rd_cnt++;
        end
        if (done) done_cnt++;
        if (busy && !done && cs_n !== 1'b0) cs_err++;
        p_sclk = sclk;
        p_mosi = mosi;
        p_dc = dc;
        p_rd = rd;
    end

    always @(negedge clk) begin
        if (sclk3 && p_sclk3 && (mosi3 !== p_mosi3 || dc3 !== p_dc3)) stab_err3++;
        if (sclk3 && !p_sclk3) begin
            if (rises3 % 8 != 0 && lo_len3 != 3) lo_err3++;
            rises3++;
            hi_len3 = 1;
            sh3 = {sh3[6:0], mosi3};
            bitc3++;
            if (bitc3 == 8) begin
                bitc3 = 0;
                if (nb3 < 16) begin
                    bytes3[nb3] = sh3;
                    bdc3[nb3] = dc3;
                end
                nb3++;
            end
        end else if (sclk3) begin
            hi_len3++;
        end else if (p_sclk3) begin
            if (hi_len3 != 3) hi_err3++;
            hi_n3++;
            lo_len3 = 1;
        end else begin
            lo_len3++;
        end
        p_sclk3 = sclk3;
        p_mosi3 = mosi3;
        p_dc3 = dc3;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nb = 0; rises = 0; bitc = 0; rd_cnt = 0; rd_err = 0; done_cnt = 0;
        stab_err = 0; cs_err = 0; hi_err = 0; lo_err = 0; hi_len = 0; lo_len = 0;
        sh = 8'h00;
    endtask

    task automatic clear_mon3();
        nb3 = 0; rises3 = 0; bitc3 = 0; stab_err3 = 0; hi_err3 = 0; lo_err3 = 0;
        hi_len3 = 0; lo_len3 = 0; hi_n3 = 0; sh3 = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int limit, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
        check({pfx, "_rd"}, 32'(rd), 32'd0);
        check({pfx, "_addr"}, 32'(addr), 32'd0);
        check({pfx, "_cs_n"}, 32'(cs_n), 32'd1);
        check({pfx, "_dc"}, 32'(dc), 32'd0);
        check({pfx, "_sclk"}, 32'(sclk), 32'd0);
        check({pfx, "_mosi"}, 32'(mosi), 32'd0);
    endtask

    initial begin
        logic ok;
        clear_mon();
        clear_mon3();
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b1;
        repeat (2) tick();
        clear_mon();

        // Frame 1: single start pulse, CLK_DIV=1.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f1_busy_on", 32'(busy), 32'd1);
        check("f1_cs_on", 32'(cs_n), 32'd0);
        wait_done(25000, "f1_done_seen");
        check("f1_done_cs_n", 32'(cs_n), 32'd1);
        check("f1_bytes", 32'(nb), 32'd1048);
        check("f1_rises", 32'(rises), 32'd8384);
        check("f1_b0", 32'(bytes[0]), 32'hB0);
        check("f1_b1", 32'(bytes[1]), 32'h10);
        check("f1_b2", 32'(bytes[2]), 32'h00);
        check("f1_dc0", 32'(bdc[0] | bdc[1] | bdc[2]), 32'd0);
        check("f1_dc3", 32'(bdc[3]), 32'd1);
        check("f1_p3_cmd", 32'(bytes[393]), 32'hB3);
        check("f1_p3c4", 32'(bytes[400]), 32'h00);
        check("f1_p3c5", 32'(bytes[401]), 32'hA5);
        check("f1_p3c5_dc", 32'(bdc[401]), 32'd1);
        check("f1_p3c6", 32'(bytes[402]), 32'h00);
        check("f1_p7_cmd", 32'(bytes[917]), 32'hB7);
        check("f1_rd_cnt", 32'(rd_cnt), 32'd1024);
        check("f1_rd_err", 32'(rd_err), 32'd0);
        check("f1_stab_err", 32'(stab_err), 32'd0);
        check("f1_cs_err", 32'(cs_err), 32'd0);
        check("f1_hi_err", 32'(hi_err), 32'd0);
        check("f1_lo_err", 32'(lo_err), 32'd0);
        check("f1_done_cnt", 32'(done_cnt), 32'd1);
        tick();
        check("f1_idle_busy", 32'(busy), 32'd0);
        check("f1_idle_done", 32'(done), 32'd0);
        repeat (3) tick();
        check("f1_stay_idle", 32'(busy), 32'd0);

        // Frames 2 and 3: start held high throughout.
        clear_mon();
        start = 1'b1;
        wait_done(25000, "f2_done_seen");
        check("f2_bytes", 32'(nb), 32'd1048);
        check("f2_rd_cnt", 32'(rd_cnt), 32'd1024);
        check("f2_rd_err", 32'(rd_err), 32'd0);
        check("f2_done_cnt", 32'(done_cnt), 32'd1);
        clear_mon();
        tick();
        check("f2_idle_after_done", 32'(busy), 32'd0);
        tick();
        check("f3_restart", 32'(busy), 32'd1);

        ok = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            tick();
            if (rd && addr == {3'd4, 7'd10}) begin
                ok = 1'b1;
                break;
            end
        end
        check("f3_reach_p4", 32'(ok), 32'd1);
        check("f3_no_done", 32'(done_cnt), 32'd0);
        check("f3_rd_err", 32'(rd_err), 32'd0);
        check("f3_b0", 32'(bytes[0]), 32'hB0);
        check("f3_p1_cmd", 32'(bytes[131]), 32'hB1);
        repeat (5) tick();
        check("f3_dc_before_rst", 32'(dc), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        clear_mon();
        repeat (5) tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_no_done", 32'(done_cnt), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rd_cnt >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("f4_first_rd", 32'(ok), 32'd1);
        check("f4_b0", 32'(bytes[0]), 32'hB0);
        check("f4_dc0", 32'(bdc[0]), 32'd0);
        check("f4_rd_err", 32'(rd_err), 32'd0);

        // CLK_DIV=3 instance: phase widths and first data bytes.
        clear_mon3();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (nb3 >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("d3_reach", 32'(ok), 32'd1);
        check("d3_b0", 32'(bytes3[0]), 32'hB0);
        check("d3_b1", 32'(bytes3[1]), 32'h10);
        check("d3_b2", 32'(bytes3[2]), 32'h00);
        check("d3_b3", 32'(bytes3[3]), 32'h5A);
        check("d3_b3_dc", 32'(bdc3[3]), 32'd1);
        check("d3_b4", 32'(bytes3[4]), 32'h5B);
        check("d3_hi_err", 32'(hi_err3), 32'd0);
        check("d3_lo_err", 32'(lo_err3), 32'd0);
        check("d3_stab_err", 32'(stab_err3), 32'd0);
        check("d3_hi_phases", 32'(hi_n3 >= 39), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
